alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Issuing side of the ALU control interface.
- Accepts one operation request: a 6-bit function code plus two 32-bit operands.
- Drives the 32-bit ALU array's signal/binvert/cin/operand inputs and captures the ALU's combinational result.
- Completes single-cycle ops (AND/OR/ADD/SUB/SLT) in one execute cycle.
- Sequences MULTU as a 32-iteration shift-add on the ALU adder and SRL as an iterative 1-bit shifter, returning result, HI and LO with a done pulse.

Parameters:
- WIDTH, 32, datapath width. The MULTU iteration count equals WIDTH.
- SHW, 5, shamt width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request strobe, sampled only when busy=0
- funct  input  6  AND=36, OR=37, ADD=32, SUB=34, SLT=42, SRL=2, MULTU=25
- src_a  input  WIDTH  operand A (MULTU multiplicand)
- src_b  input  WIDTH  operand B (MULTU multiplier; SRL source)
- shamt  input  SHW  SRL shift amount
- busy  output  1  high from the cycle after an accepted start through the DONE cycle
- done  output  1  one-cycle completion pulse
- illegal  output  1  valid with done; high when funct is unsupported
- result  output  WIDTH  result of non-MULTU ops
- hi  output  WIDTH  MULTU upper product
- lo  output  WIDTH  MULTU lower product
- alu_signal  output  6  function code to the ALU array
- alu_binvert  output  1  B invert to the ALU
- alu_cin  output  1  carry-in to bit 0
- alu_a  output  WIDTH  ALU operand A
- alu_b  output  WIDTH  ALU operand B
- alu_result  input  WIDTH  ALU combinational result
- alu_cout  input  1  ALU carry-out of the MSB

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - busy, done, illegal, result, hi, lo, alu_signal, alu_binvert, alu_cin, alu_a, alu_b are all 0.
  - The shift counter and internal operand registers are 0.
  - Reset mid-operation aborts the operation; no done is generated.
- States: IDLE, EXEC, MUL, SHIFT, DONE.
- Accept: in IDLE, start=1 latches funct/src_a/src_b/shamt. start is ignored in all other states.
  - AND/OR/ADD/SUB/SLT -> EXEC
  - MULTU -> MUL (hi_w=0, lo_w=src_b, cnt=0)
  - SRL -> SHIFT (cnt=shamt)
  - Any other code -> DONE with illegal=1; result, hi and lo are unchanged.
- EXEC (1 cycle):
  - alu_signal=funct, alu_a=src_a, alu_b=src_b.
  - alu_binvert=alu_cin=1 for SUB and SLT, else 0.
  - result <= alu_result at the end of the cycle; go to DONE.
- MUL (WIDTH cycles):
  - alu_signal=ADD, binvert=cin=0, alu_a=hi_w.
  - alu_b = src_a if lo_w[0]=1, else 0.
  - Each edge: {hi_w,lo_w} <= {alu_cout, alu_result, lo_w[WIDTH-1:1]}; cnt increments.
  - After iteration WIDTH-1: hi<=final hi_w, lo<=final lo_w; go to DONE. result is unchanged.
- SHIFT:
  - Each cycle with cnt!=0: value >>= 1 with zero fill; cnt decrements.
  - Entered with cnt==0 (shamt=0): one cycle, value unchanged.
  - When cnt reaches 0: result <= value; go to DONE.
  - The ALU drive outputs stay 0 during SHIFT.
- DONE (1 cycle): done=1, illegal valid; then go to IDLE.
- ALU drive outputs are 0 in IDLE and DONE.
- Latency, with start sampled at the end of cycle k:
  - Single-cycle op: done in cycle k+2.
  - MULTU: done in cycle k+WIDTH+1.
  - SRL: done in cycle k+max(shamt,1)+1.
  - Illegal op: done in cycle k+1.
- A new start may be sampled in the cycle after DONE, i.e. back-to-back with one IDLE cycle.
- result/hi/lo hold their values until overwritten by a later operation of the matching kind.
- Arithmetic:
  - All arithmetic is unsigned modulo 2^WIDTH. No overflow flag.
  - MULTU is the exact 2*WIDTH-bit unsigned product.

Optional Feature:
- ALU_SEQ_MULTU_EN defined: MUL state, hi/lo datapath and the MULTU decode are present.
- ALU_SEQ_MULTU_EN undefined:
  - MULTU decodes as illegal (done in cycle k+1, illegal=1).
  - hi and lo are tied to 0.
  - No MUL state exists.

Test Plan:
- ADD src_a=0x7FFFFFFF, src_b=1, ALU model attached -> alu_signal=32, binvert=0, cin=0 in cycle k+1; result=0x80000000, done in k+2, illegal=0.
- SUB 5-7, then SLT 3 vs 9 -> binvert=cin=1 during EXEC; result=0xFFFFFFFE, then result=1.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> done exactly 33 cycles after the start sample; hi=0xFFFFFFFE, lo=0x00000001, result unchanged.
- SRL src_b=0x80000000 with shamt=31 -> result=1 in k+32; shamt=0 -> result=0x80000000 in k+2.
- funct=6'd63, and start pulsed while busy during MULTU -> illegal=1 with done in k+1; the mid-MUL start is ignored, with no extra done.
- Reset asserted at iteration 10 of MULTU -> all outputs immediately 0, no done; a fresh ADD 2+2 afterwards gives result=4.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer_if
//  Purpose  : Request/response and ALU-array drive bundle between an
//             operation requester and the ALU operation sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
);
   // request side
   logic             start;
   logic [5:0]       funct;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic [SHW-1:0]   shamt;
   // response side
   logic             busy;
   logic             done;
   logic             illegal;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   // ALU array drive and return
   logic [5:0]       alu_signal;
   logic             alu_binvert;
   logic             alu_cin;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_cout;

   // requester plus ALU array
   modport master (
      output start, funct, src_a, src_b, shamt, alu_result, alu_cout,
      input  busy, done, illegal, result, hi, lo,
             alu_signal, alu_binvert, alu_cin, alu_a, alu_b
   );

   // the sequencer itself
   modport slave (
      input  start, funct, src_a, src_b, shamt, alu_result, alu_cout,
      output busy, done, illegal, result, hi, lo,
             alu_signal, alu_binvert, alu_cin, alu_a, alu_b
   );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_op_sequencer
//  Purpose  : Issues one operation at a time to an external combinational
//             ALU array. AND/OR/ADD/SUB/SLT complete in one execute cycle,
//             SRL runs as an iterative 1-bit shifter and MULTU (optional)
//             runs as a WIDTH-step shift-add on the ALU adder.
//  Options  : ALU_SEQ_MULTU_EN - include the MULTU path (MUL state, HI/LO).
//  Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input wire                clk,
   input wire                reset,
   alu_op_sequencer_if.slave bus
);

   localparam logic [5:0] c_funct_and   = 6'd36;
   localparam logic [5:0] c_funct_or    = 6'd37;
   localparam logic [5:0] c_funct_add   = 6'd32;
   localparam logic [5:0] c_funct_sub   = 6'd34;
   localparam logic [5:0] c_funct_slt   = 6'd42;
   localparam logic [5:0] c_funct_srl   = 6'd2;
`ifdef ALU_SEQ_MULTU_EN
   localparam logic [5:0] c_funct_multu = 6'd25;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_EXEC  = 3'd1,
`ifdef ALU_SEQ_MULTU_EN
      S_MUL   = 3'd2,
`endif
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t           r_state;
   logic             r_busy;
   logic             r_done;
   logic             r_illegal;
   logic [WIDTH-1:0] r_result;
   // SRL shift value, and the running low product word during MULTU
   logic [WIDTH-1:0] r_value;
   logic [SHW-1:0]   r_cnt;
   logic [5:0]       r_alu_signal;
   logic             r_alu_binvert;
   logic             r_alu_cin;
   // during MULTU r_alu_a is the running high product word
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;

`ifdef ALU_SEQ_MULTU_EN
   logic [WIDTH-1:0] r_src_a;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] w_hi_next;
   logic [WIDTH-1:0] w_lo_next;

   // one shift-add step: {cout, sum, lo} shifted right by one
   assign w_hi_next = {bus.alu_cout, bus.alu_result[WIDTH-1:1]};
   assign w_lo_next = {bus.alu_result[0], r_value[WIDTH-1:1]};
`else
   logic w_unused_alu_cout;
   assign w_unused_alu_cout = bus.alu_cout;
`endif

   // Sequencer FSM with all status, result and ALU drive outputs registered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_illegal     <= 1'b0;
         r_result      <= '0;
         r_value       <= '0;
         r_cnt         <= '0;
         r_alu_signal  <= '0;
         r_alu_binvert <= 1'b0;
         r_alu_cin     <= 1'b0;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
`ifdef ALU_SEQ_MULTU_EN
         r_src_a       <= '0;
         r_hi          <= '0;
         r_lo          <= '0;
`endif
      end else begin
         r_done    <= 1'b0;
         r_illegal <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_busy  <= 1'b1;
                  r_value <= bus.src_b;
                  case (bus.funct)
                     c_funct_and, c_funct_or, c_funct_add: begin
                        r_state       <= S_EXEC;
                        r_alu_signal  <= bus.funct;
                        r_alu_binvert <= 1'b0;
                        r_alu_cin     <= 1'b0;
                        r_alu_a       <= bus.src_a;
                        r_alu_b       <= bus.src_b;
                     end
                     c_funct_sub, c_funct_slt: begin
                        r_state       <= S_EXEC;
                        r_alu_signal  <= bus.funct;
                        r_alu_binvert <= 1'b1;
                        r_alu_cin     <= 1'b1;
                        r_alu_a       <= bus.src_a;
                        r_alu_b       <= bus.src_b;
                     end
`ifdef ALU_SEQ_MULTU_EN
                     c_funct_multu: begin
                        // first step pre-computed: hi starts at 0, lo = multiplier
                        r_state      <= S_MUL;
                        r_src_a      <= bus.src_a;
                        r_cnt        <= '0;
                        r_alu_signal <= c_funct_add;
                        r_alu_a      <= '0;
                        r_alu_b      <= bus.src_b[0] ? bus.src_a : '0;
                     end
`endif
                     c_funct_srl: begin
                        r_state <= S_SHIFT;
                        r_cnt   <= bus.shamt;
                     end
                     default: begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_illegal <= 1'b1;
                     end
                  endcase
               end
            end

            S_EXEC: begin
               r_result      <= bus.alu_result;
               r_alu_signal  <= '0;
               r_alu_binvert <= 1'b0;
               r_alu_cin     <= 1'b0;
               r_alu_a       <= '0;
               r_alu_b       <= '0;
               r_done        <= 1'b1;
               r_state       <= S_DONE;
            end

`ifdef ALU_SEQ_MULTU_EN
            S_MUL: begin
               r_value <= w_lo_next;
               if (r_cnt == SHW'(WIDTH - 1)) begin
                  r_hi         <= w_hi_next;
                  r_lo         <= w_lo_next;
                  r_cnt        <= '0;
                  r_alu_signal <= '0;
                  r_alu_a      <= '0;
                  r_alu_b      <= '0;
                  r_done       <= 1'b1;
                  r_state      <= S_DONE;
               end else begin
                  // next addend chosen by the bit that becomes lo[0]
                  r_alu_a <= w_hi_next;
                  r_alu_b <= w_lo_next[0] ? r_src_a : '0;
                  r_cnt   <= r_cnt + 1'b1;
               end
            end
`endif

            S_SHIFT: begin
               // the last shift (or the single pass for shamt=0) goes straight to result
               if (r_cnt <= SHW'(1)) begin
                  r_result <= (r_cnt == '0) ? r_value : (r_value >> 1);
                  r_cnt    <= '0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_value <= r_value >> 1;
                  r_cnt   <= r_cnt - 1'b1;
               end
            end

            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.illegal     = r_illegal;
   assign bus.result      = r_result;
   assign bus.alu_signal  = r_alu_signal;
   assign bus.alu_binvert = r_alu_binvert;
   assign bus.alu_cin     = r_alu_cin;
   assign bus.alu_a       = r_alu_a;
   assign bus.alu_b       = r_alu_b;
`ifdef ALU_SEQ_MULTU_EN
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;
`else
   assign bus.hi          = '0;
   assign bus.lo          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_op_sequencer
//  Purpose  : Directed, table-driven bench for alu_op_sequencer with a
//             behavioural model of the external ALU array attached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

   localparam int W = 32;

   localparam logic [5:0] F_AND   = 6'd36;
   localparam logic [5:0] F_OR    = 6'd37;
   localparam logic [5:0] F_ADD   = 6'd32;
   localparam logic [5:0] F_SUB   = 6'd34;
   localparam logic [5:0] F_SLT   = 6'd42;
   localparam logic [5:0] F_SRL   = 6'd2;
   localparam logic [5:0] F_MULTU = 6'd25;

`ifdef ALU_SEQ_MULTU_EN
   localparam logic [5:0]   V12_F   = 6'd0;
   localparam logic [5:0]   LONG_F  = F_MULTU;
   localparam logic [4:0]   LONG_SH = 5'd0;
   localparam int           LONG_LAT = 33;
   localparam logic [W-1:0] LONG_RES = 32'h0000_0030;
`else
   localparam logic [5:0]   V12_F   = F_MULTU;
   localparam logic [5:0]   LONG_F  = F_SRL;
   localparam logic [4:0]   LONG_SH = 5'd31;
   localparam int           LONG_LAT = 32;
   localparam logic [W-1:0] LONG_RES = 32'h0000_0001;
`endif

   typedef struct {
      logic [5:0]   funct;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [4:0]   shamt;
      logic [W-1:0] exp_result;
      logic         exp_illegal;
      int           exp_lat;
      logic [5:0]   exp_sig;
      logic         exp_inv;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   alu_op_sequencer_if #(.WIDTH(W), .SHW(5)) bus ();

   alu_op_sequencer #(.WIDTH(W), .SHW(5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural ALU array
   logic [W-1:0] m_b;
   logic [W:0]   m_sum;
   always_comb begin
      m_b   = bus.alu_binvert ? ~bus.alu_b : bus.alu_b;
      m_sum = {1'b0, bus.alu_a} + {1'b0, m_b} + {{W{1'b0}}, bus.alu_cin};
      bus.alu_cout = m_sum[W];
      case (bus.alu_signal)
         F_AND:        bus.alu_result = bus.alu_a & bus.alu_b;
         F_OR:         bus.alu_result = bus.alu_a | bus.alu_b;
         F_ADD, F_SUB: bus.alu_result = m_sum[W-1:0];
         F_SLT:        bus.alu_result = W'($signed(bus.alu_a) < $signed(bus.alu_b));
         default:      bus.alu_result = '0;
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // called at a negedge; returns at the negedge of the done cycle (lat=-1 on timeout)
   task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [4:0] sh, output int lat, output logic [5:0] sig1,
                         output logic inv1, output logic cin1);
      bus.start = 1'b1;
      bus.funct = f;
      bus.src_a = a;
      bus.src_b = b;
      bus.shamt = sh;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      sig1 = bus.alu_signal;
      inv1 = bus.alu_binvert;
      cin1 = bus.alu_cin;
      lat  = 1;
      while (!bus.done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      if (!bus.done) lat = -1;
   endtask

   task automatic check_all_zero(input string pfx);
      check({pfx, "_ctrl"}, 64'({bus.busy, bus.done, bus.illegal, bus.alu_binvert,
                                 bus.alu_cin, bus.alu_signal}), 64'd0);
      check({pfx, "_result"}, 64'(bus.result), 64'd0);
      check({pfx, "_hilo"}, {bus.hi, bus.lo}, 64'd0);
      check({pfx, "_alu_ab"}, {bus.alu_a, bus.alu_b}, 64'd0);
   endtask

   initial begin
      int lat;
      int first;
      int n_done;
      logic [5:0] sig1;
      logic inv1;
      logic cin1;

      n_checks = 0;
      n_errors = 0;

      vecs[0]  = '{F_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 2,  F_ADD, 1'b0};
      vecs[1]  = '{F_SUB, 32'h0000_0005, 32'h0000_0007, 5'd0,  32'hFFFF_FFFE, 1'b0, 2,  F_SUB, 1'b1};
      vecs[2]  = '{F_SLT, 32'h0000_0003, 32'h0000_0009, 5'd0,  32'h0000_0001, 1'b0, 2,  F_SLT, 1'b1};
      vecs[3]  = '{F_SLT, 32'h0000_0009, 32'h0000_0003, 5'd0,  32'h0000_0000, 1'b0, 2,  F_SLT, 1'b1};
      vecs[4]  = '{F_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0,  32'h00F0_1200, 1'b0, 2,  F_AND, 1'b0};
      vecs[5]  = '{F_OR,  32'hF000_0001, 32'h0000_00F0, 5'd0,  32'hF000_00F1, 1'b0, 2,  F_OR,  1'b0};
      vecs[6]  = '{F_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0, 2,  F_ADD, 1'b0};
      vecs[7]  = '{F_SRL, 32'hFFFF_FFFF, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 32, 6'd0,  1'b0};
      vecs[8]  = '{F_SRL, 32'hFFFF_FFFF, 32'h8000_0000, 5'd0,  32'h8000_0000, 1'b0, 2,  6'd0,  1'b0};
      vecs[9]  = '{F_SRL, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 5'd4,  32'h0DEA_DBEE, 1'b0, 5,  6'd0,  1'b0};
      vecs[10] = '{6'd63, 32'h1111_1111, 32'h2222_2222, 5'd3,  32'h0DEA_DBEE, 1'b1, 1,  6'd0,  1'b0};
      vecs[11] = '{F_SRL, 32'h0000_0000, 32'h1234_5678, 5'd1,  32'h091A_2B3C, 1'b0, 2,  6'd0,  1'b0};
      vecs[12] = '{V12_F, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'h091A_2B3C, 1'b1, 1,  6'd0,  1'b0};
      vecs[13] = '{F_ADD, 32'h0000_0010, 32'h0000_0020, 5'd0,  32'h0000_0030, 1'b0, 2,  F_ADD, 1'b0};

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.funct = '0;
      bus.src_a = '0;
      bus.src_b = '0;
      bus.shamt = '0;
      @(negedge clk);
      @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      // table of single operations, issued back-to-back with one idle cycle
      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].shamt, lat, sig1, inv1, cin1);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         check($sformatf("v%0d_result", i), 64'(bus.result), 64'(vecs[i].exp_result));
         check($sformatf("v%0d_illegal", i), 64'(bus.illegal), 64'(vecs[i].exp_illegal));
         check($sformatf("v%0d_alu_signal", i), 64'(sig1), 64'(vecs[i].exp_sig));
         check($sformatf("v%0d_binv_cin", i), 64'({inv1, cin1}), 64'({vecs[i].exp_inv, vecs[i].exp_inv}));
         @(negedge clk);
         check($sformatf("v%0d_after_done", i), 64'({bus.done, bus.busy}), 64'd0);
      end
      check("table_hilo", {bus.hi, bus.lo}, 64'd0);

      // long operation with a start pulse while busy: exactly one done
      bus.start = 1'b1;
      bus.funct = LONG_F;
      bus.src_a = 32'hFFFF_FFFF;
      bus.src_b = (LONG_F == F_SRL) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      bus.shamt = LONG_SH;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      n_done = 0;
      first  = -1;
      for (int c = 1; c <= 60; c++) begin
         if (c == 5) begin
            bus.start = 1'b1;
            bus.funct = F_ADD;
            bus.src_a = 32'd1;
            bus.src_b = 32'd1;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done) begin
            n_done++;
            if (first < 0) first = c;
         end
         @(negedge clk);
      end
      check("busy_start_latency", 64'(first), 64'(LONG_LAT));
      check("busy_start_done_count", 64'(n_done), 64'd1);
      check("busy_start_result", 64'(bus.result), 64'(LONG_RES));
`ifdef ALU_SEQ_MULTU_EN
      check("multu_max_hilo", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);

      run_op(F_MULTU, 32'd3, 32'd5, 5'd0, lat, sig1, inv1, cin1);
      check("multu_3x5_latency", 64'(lat), 64'd33);
      check("multu_3x5_hilo", {bus.hi, bus.lo}, 64'h0000_0000_0000_000F);
      check("multu_3x5_drive", 64'({sig1, inv1, cin1}), 64'({F_ADD, 2'b00}));
      check("multu_3x5_result", 64'(bus.result), 64'h30);
      @(negedge clk);
      run_op(F_MULTU, 32'h8000_0000, 32'd2, 5'd0, lat, sig1, inv1, cin1);
      check("multu_msb_hilo", {bus.hi, bus.lo}, 64'h0000_0001_0000_0000);
      @(negedge clk);
`endif

      // reset during iteration 10 of a long operation
      bus.start = 1'b1;
      bus.funct = LONG_F;
      bus.src_a = 32'hFFFF_FFFF;
      bus.src_b = (LONG_F == F_SRL) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      bus.shamt = LONG_SH;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("midop_reset");
      @(negedge clk);
      reset = 1'b0;
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      check("midop_reset_no_done", 64'(n_done), 64'd0);
      run_op(F_ADD, 32'd2, 32'd2, 5'd0, lat, sig1, inv1, cin1);
      check("post_reset_add_latency", 64'(lat), 64'd2);
      check("post_reset_add_result", 64'(bus.result), 64'd4);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
